// File: rtl/n_bit_serializer.sv
// n_bit_serializer
// ----------------
// Parallel-in, serial-out transmitter. A word is taken over a valid/ready
// handshake and shifted out one bit per clock, MSB-first or LSB-first as
// chosen per word. Supports stalling, a last-bit marker, a done pulse and
// back-to-back words with no idle gap between them.
//
// Parameters
//   n   word width in bits (n >= 2)
//   CW  bit-counter width (2**CW >= n)
//
// Ports
//   clk         rising-edge clock
//   clr         synchronous reset, active-high
//   D           parallel word to transmit
//   load_valid  D and lsb_first are valid this cycle
//   load_ready  block accepts a word this cycle
//   lsb_first   bit order for the word, sampled on accept (1 = D[0] first)
//   pause       stall: hold the current bit, do not advance
//   sout        serial data bit (0 whenever sout_valid is low)
//   sout_valid  sout carries a transferred bit this cycle
//   last        sout is the final bit of the current word
//   busy        a word is in flight
//   done        one-cycle pulse after the final bit of a word transfers

module n_bit_serializer #(
    parameter int n  = 4,
    parameter int CW = 3
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [n-1:0] D,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         lsb_first,
    input  logic         pause,
    output logic         sout,
    output logic         sout_valid,
    output logic         last,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [n-1:0]    sr_q, sr_d;
    logic            ord_q, ord_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;

    logic            accept;
    logic            advance;

    // Output decoding straight from registered state. The counter reaching
    // zero marks the final bit; a stalled last bit must not take a new word,
    // otherwise the word on the wire would be overwritten before it transfers.
    assign busy       = (state_q == SHIFT);
    assign sout_valid = busy & ~pause;
    assign sout       = sout_valid ? (ord_q ? sr_q[0] : sr_q[n-1]) : 1'b0;
    assign last       = busy & (cnt_q == '0);
    assign load_ready = ~clr & (~busy | (last & ~pause));
    assign done       = done_q;

    assign accept  = load_valid & load_ready;
    assign advance = busy & ~pause;

    // Next-state logic. A transferred bit shifts the register toward the
    // output end and counts down; the final bit ends the word and raises done.
    // An accept is applied last so that a word arriving on the final bit
    // takes over directly and the link stays busy with no gap.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        ord_d   = ord_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (advance) begin
            sr_d = ord_q ? (sr_q >> 1) : (sr_q << 1);
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end

        if (accept) begin
            sr_d    = D;
            ord_d   = lsb_first;
            cnt_d   = CW'(n - 1);
            state_d = SHIFT;
        end
    end

    // State register. Reset aborts any word in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            sr_q    <= '0;
            ord_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            ord_q   <= ord_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_n_bit_serializer.sv
// tb_n_bit_serializer
// -------------------
// Bench for n_bit_serializer with n=4. A table of per-cycle vectors walks
// through plain MSB/LSB words, stalls, back-to-back words, rejected loads
// and a mid-word reset; a short hand-written sequence covers reset during a
// stall; a randomized run is checked against a queue-based model of the
// bit stream.

module tb_n_bit_serializer;

    localparam int N  = 4;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic [N-1:0] D = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         lsb_first = 1'b0;
    logic         pause = 1'b0;
    logic         sout;
    logic         sout_valid;
    logic         last;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    n_bit_serializer #(.n(N), .CW(CW)) dut (
        .clk        (clk),
        .clr        (clr),
        .D          (D),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .lsb_first  (lsb_first),
        .pause      (pause),
        .sout       (sout),
        .sout_valid (sout_valid),
        .last       (last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // One table row is one clock cycle: the inputs held during that cycle
    // and the outputs expected before its rising edge, packed as
    // {load_ready, sout, sout_valid, last, busy, done}.
    typedef struct {
        logic         clr;
        logic         lv;
        logic [N-1:0] d;
        logic         lsb;
        logic         pause;
        logic [5:0]   exp;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the bits still to be sent for the current word, in
    // transmission order, plus the pending done pulse.
    bit modelQ[$];
    bit modelDone = 1'b0;

    function automatic logic [5:0] modelExpect();
        logic b, v, l, r, s;
        b = (modelQ.size() != 0);
        v = b & ~pause;
        l = (modelQ.size() == 1);
        r = ~clr & (~b | (l & ~pause));
        s = v ? modelQ[0] : 1'b0;
        return {r, s, v, l, b, modelDone};
    endfunction

    always @(posedge clk) begin
        int  sz;
        bit  acc;
        bit  rdy;
        sz  = modelQ.size();
        rdy = ~clr & ((sz == 0) | ((sz == 1) & ~pause));
        acc = load_valid & rdy;
        if (clr) begin
            modelQ.delete();
            modelDone = 1'b0;
        end else begin
            modelDone = (sz == 1) & ~pause;
            if (sz != 0 && !pause) void'(modelQ.pop_front());
            if (acc) begin
                modelQ.delete();
                for (int i = 0; i < N; i++)
                    modelQ.push_back(lsb_first ? D[i] : D[N-1-i]);
            end
        end
    end

    task automatic addVec(input logic c, input logic lv, input logic [N-1:0] d,
                          input logic lsb, input logic p, input logic [5:0] e);
        vec_t v;
        v.clr = c; v.lv = lv; v.d = d; v.lsb = lsb; v.pause = p; v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs just after the falling edge.
    task automatic applyStimulus(input logic c, input logic lv, input logic [N-1:0] d,
                                 input logic lsb, input logic p);
        @(negedge clk);
        clr        = c;
        load_valid = lv;
        D          = d;
        lsb_first  = lsb;
        pause      = p;
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [5:0] e);
        logic [5:0] act;
        act = {load_ready, sout, sout_valid, last, busy, done};
        total++;
        if (act !== e) begin
            bad++;
            $display("[TB] FAIL %s%0d: got {rdy,sout,vld,last,busy,done}=%b want %b",
                     name, idx, act, e);
        end
    endtask

    initial begin
        // reset state
        addVec(1, 0, 4'b0000, 0, 0, 6'b000000);
        // 1011 MSB-first: 1,0,1,1 then done
        addVec(0, 1, 4'b1011, 0, 0, 6'b100000);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b001010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b111110);
        addVec(0, 0, 4'b0000, 0, 0, 6'b100001);
        // 1011 LSB-first: 1,1,0,1
        addVec(0, 1, 4'b1011, 1, 0, 6'b100000);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b001010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b111110);
        // 1011 MSB-first, 2nd bit stalled 3 cycles with a rejected 1111 load
        addVec(0, 1, 4'b1011, 0, 0, 6'b100001);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 1, 4'b1111, 0, 1, 6'b000010);
        addVec(0, 1, 4'b1111, 0, 1, 6'b000010);
        addVec(0, 1, 4'b1111, 0, 1, 6'b000010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b001010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b111110);
        addVec(0, 0, 4'b0000, 0, 0, 6'b100001);
        // back-to-back 1011 then 0110: 1,0,1,1,0,1,1,0
        addVec(0, 1, 4'b1011, 0, 0, 6'b100000);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b001010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 1, 4'b0110, 0, 0, 6'b111110);
        addVec(0, 0, 4'b0000, 0, 0, 6'b001011);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b101110);
        addVec(0, 0, 4'b0000, 0, 0, 6'b100001);
        // load offered on a paused last bit is refused
        addVec(0, 1, 4'b1011, 0, 0, 6'b100000);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b001010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 1, 4'b1111, 0, 1, 6'b000110);
        addVec(0, 0, 4'b0000, 0, 0, 6'b111110);
        addVec(0, 0, 4'b0000, 0, 0, 6'b100001);
        // reset during bit 2, then 0110 LSB-first: 0,1,1,0
        addVec(0, 1, 4'b1011, 0, 0, 6'b100000);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(1, 0, 4'b0000, 0, 0, 6'b001010);
        addVec(0, 1, 4'b0110, 1, 0, 6'b100000);
        addVec(0, 0, 4'b0000, 0, 0, 6'b001010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b011010);
        addVec(0, 0, 4'b0000, 0, 0, 6'b101110);
        addVec(0, 0, 4'b0000, 0, 0, 6'b100001);
        addVec(0, 0, 4'b0000, 0, 0, 6'b100000);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].clr, vecs[i].lv, vecs[i].d, vecs[i].lsb, vecs[i].pause);
            checkOutput("vec", i, vecs[i].exp);
        end

        // Reset while the first bit is stalled: no done afterwards.
        applyStimulus(0, 1, 4'b1001, 0, 0); checkOutput("clrPause", 0, 6'b100000);
        applyStimulus(0, 0, 4'b0000, 0, 1); checkOutput("clrPause", 1, 6'b000010);
        applyStimulus(1, 0, 4'b0000, 0, 1); checkOutput("clrPause", 2, 6'b000010);
        applyStimulus(0, 0, 4'b0000, 0, 0); checkOutput("clrPause", 3, 6'b100000);
        applyStimulus(0, 0, 4'b0000, 0, 0); checkOutput("clrPause", 4, 6'b100000);
        // A load offered during reset is not taken.
        applyStimulus(1, 1, 4'b1111, 0, 0); checkOutput("clrLoad", 0, 6'b000000);
        applyStimulus(0, 0, 4'b0000, 0, 0); checkOutput("clrLoad", 1, 6'b100000);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 2) != 0),
                          N'($urandom_range(0, (1 << N) - 1)),
                          $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 3) == 0));
            checkOutput("rand", i, modelExpect());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
